// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: 1 Hz count-enable prescaler plus start/pause/clear/lap/alarm FSM.
// Latency: button edge to state/output change is one clk; cnt_en is registered, one cycle per tick.
// Backpressure: none; button events are single-cycle and are acted on the cycle they are seen.
//
// Ports:
//   clk, rst                      system clock (rising edge), asynchronous active-low reset
//   btn_start/btn_lap/btn_clear   debounced button levels, rising-edge detected here
//   limit_en/limit_min/limit_sec  alarm limit; values above 59 never match
//   cur_min/cur_sec               live counter value
//   cnt_en                        counter start_stop, one-cycle pulse per tick
//   cnt_clr_n                     registered active-low one-cycle counter clear
//   disp_min/disp_sec             live time, or lap-frozen time while lap_active
//   running/lap_active/alarm      status flags
module stopwatch_controller #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       limit_en,
    input  logic [5:0] limit_min,
    input  logic [5:0] limit_sec,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       cnt_en,
    output logic       cnt_clr_n,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec,
    output logic       running,
    output logic       lap_active,
    output logic       alarm
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clr_n_q, cnt_clr_n_d;
    logic          lap_active_q, lap_active_d;
    logic [5:0]    lap_min_q, lap_min_d;
    logic [5:0]    lap_sec_q, lap_sec_d;
    logic          running_q, alarm_q;
    logic          btn_start_q, btn_lap_q, btn_clear_q;

    logic start_ev, lap_ev, clr_ev, limit_match;

    // Edge registers reset to 0, so a button held through reset release gives one event.
    assign start_ev = btn_start & ~btn_start_q;
    assign lap_ev   = btn_lap   & ~btn_lap_q;
    assign clr_ev   = btn_clear & ~btn_clear_q;

    // A zero limit would fire immediately after clear, so it is treated as "no limit".
    assign limit_match = (state_q == RUN) && limit_en &&
                         ({limit_min, limit_sec} != 12'd0) &&
                         (limit_min <= 6'd59) && (limit_sec <= 6'd59) &&
                         (cur_min == limit_min) && (cur_sec == limit_sec);

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        cnt_en_d     = 1'b0;
        cnt_clr_n_d  = ~clr_ev;
        lap_active_d = lap_active_q;
        lap_min_d    = lap_min_q;
        lap_sec_d    = lap_sec_q;

        unique case (state_q)
            IDLE: begin
                if (clr_ev) begin
                    state_d = IDLE;
                end else if (start_ev) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                // Any transition event drops this cycle's tick and freezes the prescaler.
                if (clr_ev) begin
                    state_d = IDLE;
                end else if (start_ev) begin
                    state_d = PAUSE;
                end else if (limit_match) begin
                    state_d      = ALARM;
                    lap_active_d = 1'b0;
                end else begin
                    if (presc_q == PRE_MAX) begin
                        presc_d  = '0;
                        cnt_en_d = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (lap_ev) begin
                        lap_active_d = ~lap_active_q;
                        if (!lap_active_q) begin
                            lap_min_d = cur_min;
                            lap_sec_d = cur_sec;
                        end
                    end
                end
            end
            PAUSE: begin
                // Prescaler holds its partial count so resume loses no fraction of a second.
                if (clr_ev) begin
                    state_d = IDLE;
                end else if (start_ev) begin
                    state_d = RUN;
                end else if (lap_ev) begin
                    lap_active_d = ~lap_active_q;
                    if (!lap_active_q) begin
                        lap_min_d = cur_min;
                        lap_sec_d = cur_sec;
                    end
                end
            end
            ALARM: begin
                if (clr_ev) begin
                    state_d = IDLE;
                end else if (start_ev) begin
                    state_d = PAUSE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_ev) begin
            lap_active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            cnt_en_q     <= 1'b0;
            cnt_clr_n_q  <= 1'b1;
            lap_active_q <= 1'b0;
            lap_min_q    <= '0;
            lap_sec_q    <= '0;
            running_q    <= 1'b0;
            alarm_q      <= 1'b0;
            btn_start_q  <= 1'b0;
            btn_lap_q    <= 1'b0;
            btn_clear_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            cnt_en_q     <= cnt_en_d;
            cnt_clr_n_q  <= cnt_clr_n_d;
            lap_active_q <= lap_active_d;
            lap_min_q    <= lap_min_d;
            lap_sec_q    <= lap_sec_d;
            running_q    <= (state_d == RUN);
            alarm_q      <= (state_d == ALARM);
            btn_start_q  <= btn_start;
            btn_lap_q    <= btn_lap;
            btn_clear_q  <= btn_clear;
        end
    end

    assign cnt_en     = cnt_en_q;
    assign cnt_clr_n  = cnt_clr_n_q;
    assign lap_active = lap_active_q;
    assign running    = running_q;
    assign alarm      = alarm_q;
    assign disp_min   = lap_active_q ? lap_min_q : cur_min;
    assign disp_sec   = lap_active_q ? lap_sec_q : cur_sec;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with DIV=4 and a behavioural mm:ss counter
// whose reset is rst AND cnt_clr_n. Inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_controller;
    logic       clk, rst;
    logic       btn_start, btn_lap, btn_clear;
    logic       limit_en;
    logic [5:0] limit_min, limit_sec;
    logic [5:0] cur_min, cur_sec;
    logic       cnt_en, cnt_clr_n;
    logic [5:0] disp_min, disp_sec;
    logic       running, lap_active, alarm;
    logic       cnt_rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_controller #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .limit_en(limit_en), .limit_min(limit_min), .limit_sec(limit_sec),
        .cur_min(cur_min), .cur_sec(cur_sec),
        .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n),
        .disp_min(disp_min), .disp_sec(disp_sec),
        .running(running), .lap_active(lap_active), .alarm(alarm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment counter: advances on the edge that closes a cnt_en cycle.
    assign cnt_rst_n = rst & cnt_clr_n;
    always_ff @(posedge clk or negedge cnt_rst_n) begin
        if (!cnt_rst_n) begin
            cur_min <= '0;
            cur_sec <= '0;
        end else if (cnt_en) begin
            if (cur_sec == 6'd59) begin
                cur_sec <= '0;
                cur_min <= (cur_min == 6'd59) ? 6'd0 : cur_min + 6'd1;
            end else begin
                cur_sec <= cur_sec + 6'd1;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; btn_start = 0; btn_lap = 0; btn_clear = 0;
        limit_en = 0; limit_min = '0; limit_sec = '0;
        cyc(); cyc();
        n_tests++; if ({cnt_en, cnt_clr_n, running, lap_active, alarm} !== 5'b01000) begin n_fail++; $display("FAIL reset_flags got=%b want=01000", {cnt_en, cnt_clr_n, running, lap_active, alarm}); end
        n_tests++; if ({disp_min, disp_sec} !== 12'd0) begin n_fail++; $display("FAIL reset_disp got=%0d:%0d want=0:0", disp_min, disp_sec); end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        n_tests++; if ({cnt_en, running, alarm, cnt_clr_n} !== 4'b0001) begin n_fail++; $display("FAIL idle_after_release got=%b want=0001", {cnt_en, running, alarm, cnt_clr_n}); end
    endtask

    task automatic test_run();
        btn_start = 1; cyc(); btn_start = 0;
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_running got=%b want=1", running); end
        for (int i = 0; i <= 12; i++) begin
            n_tests++; if (cnt_en !== ((i % 4 == 0) && i != 0)) begin n_fail++; $display("FAIL run_cnt_en cycle=%0d got=%b want=%b", i, cnt_en, ((i % 4 == 0) && i != 0)); end
            if (i < 12) cyc();
        end
        cyc();
        n_tests++; if ({cur_min, cur_sec} !== {6'd0, 6'd3}) begin n_fail++; $display("FAIL run_count got=%0d:%0d want=0:3", cur_min, cur_sec); end
    endtask

    task automatic test_pause_resume();
        // Now on the 1st RUN cycle after a tick; press start on the 2nd.
        cyc();
        btn_start = 1; cyc(); btn_start = 0;
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running got=%b want=0", running); end
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (cnt_en !== 1'b0 || cur_sec !== 6'd3) begin n_fail++; $display("FAIL pause_hold cycle=%0d cnt_en=%b sec=%0d want 0,3", i, cnt_en, cur_sec); end
            cyc();
        end
        btn_start = 1; cyc(); btn_start = 0;
        n_tests++; if (running !== 1'b1 || cnt_en !== 1'b0) begin n_fail++; $display("FAIL resume_r0 running=%b cnt_en=%b want 1,0", running, cnt_en); end
        cyc();
        n_tests++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL resume_r1 cnt_en got=%b want=0", cnt_en); end
        cyc();
        n_tests++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL resume_r2 cnt_en got=%b want=1", cnt_en); end
        cyc();
        n_tests++; if (cur_sec !== 6'd4) begin n_fail++; $display("FAIL resume_count got=%0d want=4", cur_sec); end
    endtask

    task automatic test_lap();
        for (int k = 0; k < 20 && cur_sec !== 6'd5; k++) cyc();
        n_tests++; if (cur_sec !== 6'd5) begin n_fail++; $display("FAIL lap_wait5 got=%0d want=5", cur_sec); end
        btn_lap = 1; cyc(); btn_lap = 0;
        n_tests++; if (lap_active !== 1'b1) begin n_fail++; $display("FAIL lap_set got=%b want=1", lap_active); end
        for (int k = 0; k < 20 && cur_sec !== 6'd7; k++) begin
            n_tests++; if ({disp_min, disp_sec} !== {6'd0, 6'd5}) begin n_fail++; $display("FAIL lap_frozen got=%0d:%0d want=0:5", disp_min, disp_sec); end
            cyc();
        end
        n_tests++; if (cur_sec !== 6'd7 || disp_sec !== 6'd5) begin n_fail++; $display("FAIL lap_at7 cur=%0d disp=%0d want 7,5", cur_sec, disp_sec); end
        btn_lap = 1; cyc(); btn_lap = 0;
        n_tests++; if (lap_active !== 1'b0 || disp_sec !== 6'd7) begin n_fail++; $display("FAIL lap_release lap=%b disp=%0d want 0,7", lap_active, disp_sec); end
    endtask

    task automatic test_alarm();
        btn_clear = 1; cyc(); btn_clear = 0;
        n_tests++; if (running !== 1'b0 || cnt_clr_n !== 1'b0 || cur_sec !== 6'd0) begin n_fail++; $display("FAIL alarm_preclear running=%b clr_n=%b sec=%0d want 0,0,0", running, cnt_clr_n, cur_sec); end
        cyc();
        limit_en = 1; limit_min = 6'd0; limit_sec = 6'd3;
        btn_start = 1; cyc(); btn_start = 0;
        for (int k = 0; k < 30 && cur_sec !== 6'd3; k++) cyc();
        n_tests++; if (cur_sec !== 6'd3 || alarm !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL alarm_at3 sec=%0d alarm=%b running=%b want 3,0,1", cur_sec, alarm, running); end
        cyc();
        n_tests++; if (alarm !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL alarm_set alarm=%b running=%b want 1,0", alarm, running); end
        for (int i = 0; i < 12; i++) begin
            n_tests++; if (cnt_en !== 1'b0 || cur_sec !== 6'd3) begin n_fail++; $display("FAIL alarm_hold cycle=%0d cnt_en=%b sec=%0d want 0,3", i, cnt_en, cur_sec); end
            cyc();
        end
        btn_start = 1; cyc(); btn_start = 0;
        n_tests++; if (alarm !== 1'b0 || running !== 1'b0 || cur_sec !== 6'd3) begin n_fail++; $display("FAIL alarm_ack alarm=%b running=%b sec=%0d want 0,0,3", alarm, running, cur_sec); end
        btn_clear = 1; cyc(); btn_clear = 0;
        n_tests++; if (cnt_clr_n !== 1'b0 || cur_sec !== 6'd0) begin n_fail++; $display("FAIL alarm_clear clr_n=%b sec=%0d want 0,0", cnt_clr_n, cur_sec); end
        cyc();
        n_tests++; if (cnt_clr_n !== 1'b1 || running !== 1'b0 || alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_idle clr_n=%b running=%b alarm=%b want 1,0,0", cnt_clr_n, running, alarm); end
        limit_en = 0;
    endtask

    task automatic test_coincident();
        btn_start = 1; cyc(); btn_start = 0;
        btn_lap = 1; cyc(); btn_lap = 0;
        n_tests++; if (lap_active !== 1'b1) begin n_fail++; $display("FAIL coinc_lap_set got=%b want=1", lap_active); end
        cyc(); cyc();
        // Fourth RUN cycle: the prescaler would wrap here.
        btn_clear = 1; btn_start = 1; btn_lap = 1; cyc();
        btn_clear = 0; btn_start = 0; btn_lap = 0;
        n_tests++; if ({running, cnt_clr_n, lap_active, cnt_en} !== 4'b0000) begin n_fail++; $display("FAIL coinc_clear_wins got=%b want=0000", {running, cnt_clr_n, lap_active, cnt_en}); end
        cyc();
        n_tests++; if ({running, cnt_clr_n, cnt_en} !== 3'b010) begin n_fail++; $display("FAIL coinc_after got=%b want=010", {running, cnt_clr_n, cnt_en}); end
    endtask

    task automatic test_reset_mid_run();
        btn_start = 1; cyc(); btn_start = 0;
        btn_lap = 1; cyc(); btn_lap = 0;
        for (int k = 0; k < 10 && cnt_en !== 1'b1; k++) cyc();
        n_tests++; if (cnt_en !== 1'b1 || lap_active !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre cnt_en=%b lap=%b want 1,1", cnt_en, lap_active); end
        rst = 1'b0;
        #1;
        n_tests++; if ({cnt_en, cnt_clr_n, running, lap_active, alarm} !== 5'b01000) begin n_fail++; $display("FAIL rstmid_flags got=%b want=01000", {cnt_en, cnt_clr_n, running, lap_active, alarm}); end
        n_tests++; if ({disp_min, disp_sec} !== 12'd0) begin n_fail++; $display("FAIL rstmid_disp got=%0d:%0d want=0:0", disp_min, disp_sec); end
        cyc(); cyc();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_tests++; if (cnt_en !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet cycle=%0d cnt_en=%b running=%b want 0,0", i, cnt_en, running); end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause_resume();
        test_lap();
        test_alarm();
        test_coincident();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Sequences the minutes:seconds counter, which advances one second per clock while its start_stop enable is high.
- Turns the raw system clock into a single-cycle 1 Hz count enable and runs the start/pause/clear/lap/alarm state machine from debounced buttons.
- Supplies the display path with either live or lap-frozen time.
- Sits between the debouncers and the counter. At top level, counter rst = rst AND cnt_clr_n.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 1, count-enable rate; DIV = CLK_HZ/TICK_HZ (must be >= 2); prescaler width = $clog2(DIV)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
btn_start  input  1  debounced level, start/pause/acknowledge
btn_lap  input  1  debounced level, lap toggle
btn_clear  input  1  debounced level, clear
limit_en  input  1  enable alarm limit
limit_min  input  6  alarm minutes
limit_sec  input  6  alarm seconds
cur_min  input  6  counter minutes
cur_sec  input  6  counter seconds
cnt_en  output  1  to counter start_stop, one-cycle pulse per tick
cnt_clr_n  output  1  registered active-low one-cycle counter clear
disp_min  output  6  displayed minutes
disp_sec  output  6  displayed seconds
running  output  1  high in RUN
lap_active  output  1  display frozen
alarm  output  1  high in ALARM

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, prescaler=0, lap regs=0.
  - cnt_en=0, cnt_clr_n=1, running=0, lap_active=0, alarm=0.
  - Button edge-detect registers are cleared to 0. A button held through reset release therefore yields one edge on the first cycle.
- Buttons:
  - Each button is rising-edge detected internally (sample vs previous sample). An "event" is one cycle wide.
  - Priority when events coincide: clear > start > lap.
- States and transitions (each takes effect on the next clk edge):
  - IDLE: start -> RUN with prescaler=0. Clear -> pulse cnt_clr_n, stay in IDLE. Lap is ignored.
  - RUN: clear -> IDLE with cnt_clr_n pulse. Start -> PAUSE. Limit match -> ALARM.
  - PAUSE: clear -> IDLE with cnt_clr_n pulse. Start -> RUN. The prescaler keeps its partial count, so a pause loses no fraction of a second.
  - ALARM: start -> PAUSE (acknowledge, time kept). Clear -> IDLE with cnt_clr_n pulse. Lap is ignored.
- Prescaler:
  - Increments only in RUN.
  - At DIV-1 it wraps to 0 and sets the registered cnt_en for exactly the following cycle.
  - First cnt_en is high exactly DIV cycles after the first RUN cycle.
  - cnt_en is never high outside RUN, except that a pulse already registered is still emitted in its cycle.
  - A tick suppressed in the same cycle by a start, clear or limit-match event is dropped.
- Limit match:
  - Condition: state=RUN, limit_en=1, {limit_min,limit_sec} != 0, cur_min==limit_min, cur_sec==limit_sec.
  - Evaluated every cycle.
  - Limit values above 59 never match.
  - The counter updates the cycle after cnt_en, so the match is seen before the next tick.
- Lap:
  - A lap event in RUN or PAUSE toggles lap_active.
  - On set, cur_min/cur_sec are latched into the lap regs.
  - lap_active clears on any clear event, on entry to ALARM, and on reset.
- Display: combinational mux. disp = lap_active ? lap regs : cur.
- cnt_clr_n: low for exactly one cycle, the cycle after a clear event. It is registered, so it is glitch-free.
- running=(state==RUN), alarm=(state==ALARM). Both are registered state decodes.
- Widths: all time fields are 6 bits. No arithmetic on time values, only equality compares.

Test Plan:
(DIV=4 unless stated; bench models the counter with rst AND cnt_clr_n.)
1. Reset, then a start edge -> running=1 next cycle; cnt_en pulses on RUN cycles 4, 8, 12; counter reads 00:03 after the third pulse; all outputs at reset values before the start edge.
2. Start edge on the 2nd RUN cycle after a tick, then start again 10 cycles later -> PAUSE with no cnt_en; after resume, next cnt_en arrives 2 cycles later (partial count retained).
3. At 00:05, lap edge -> disp stays 00:05 while counter reaches 00:07; second lap edge -> disp=00:07 same cycle.
4. limit_en=1, limit=00:03 -> alarm=1 one cycle after the counter shows 00:03; no further cnt_en; start edge -> PAUSE at 00:03; clear edge -> cnt_clr_n low one cycle, counter 00:00, IDLE.
5. Clear, start and lap edges in the same RUN cycle -> clear wins: IDLE, cnt_clr_n pulse, lap_active=0, no cnt_en.
6. rst low mid-RUN, coinciding with a tick -> all outputs return to reset values immediately; no cnt_en for 10 cycles after release without a start edge.
